ram512x8_sdp: RTL and testbench

- Simple-dual-port 512-word x 8-bit synchronous block RAM with one write port and one registered read port.
- Initial contents are set by parameters.
- Used as the camera line/pixel buffer between the camera capture logic and the SPI readout logic.
- Single clock domain; asynchronous active-low reset clears only the read-data register.

---
 rtl/ram512x8_sdp.sv | 142 ++++++++++++++
 tb/tb_ram512x8_sdp.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram512x8_sdp.sv
// ----------------------------------------------------------------------------
// ram512x8_sdp
//   Simple-dual-port 512 x 8 synchronous RAM used as the camera line/pixel
//   buffer. It has one write port and one read port with a registered output.
//   Both ports run on a single clock. The memory image is preloaded from the
//   INIT_0..INIT_F parameters. Reset clears only the read-data register and
//   never the array.
//
// Parameters
//   INIT_0..INIT_F  256-bit slices of the initial image. INIT_n[8k+7:8k] holds
//                   word n*32+k, so INIT_0[7:0] is address 0 and
//                   INIT_F[255:248] is address 511.
//
// Ports
//   clk    in   1  rising-edge clock for both ports
//   rstn   in   1  asynchronous active-low reset (clears rdata only)
//   rdata  out  8  registered read data, valid one edge after raddr is sampled
//   raddr  in   9  read address
//   rclke  in   1  read-port clock enable
//   re     in   1  read enable
//   waddr  in   9  write address
//   wclke  in   1  write-port clock enable
//   wdata  in   8  write data
//   we     in   1  write enable
// ----------------------------------------------------------------------------
module ram512x8_sdp #(
  parameter logic [255:0] INIT_0 = 256'h0,
  parameter logic [255:0] INIT_1 = 256'h0,
  parameter logic [255:0] INIT_2 = 256'h0,
  parameter logic [255:0] INIT_3 = 256'h0,
  parameter logic [255:0] INIT_4 = 256'h0,
  parameter logic [255:0] INIT_5 = 256'h0,
  parameter logic [255:0] INIT_6 = 256'h0,
  parameter logic [255:0] INIT_7 = 256'h0,
  parameter logic [255:0] INIT_8 = 256'h0,
  parameter logic [255:0] INIT_9 = 256'h0,
  parameter logic [255:0] INIT_A = 256'h0,
  parameter logic [255:0] INIT_B = 256'h0,
  parameter logic [255:0] INIT_C = 256'h0,
  parameter logic [255:0] INIT_D = 256'h0,
  parameter logic [255:0] INIT_E = 256'h0,
  parameter logic [255:0] INIT_F = 256'h0
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [7:0] rdata,
  input  logic [8:0] raddr,
  input  logic       rclke,
  input  logic       re,
  input  logic [8:0] waddr,
  input  logic       wclke,
  input  logic [7:0] wdata,
  input  logic       we
);

  localparam int unsigned DEPTH          = 512;
  localparam int unsigned WORDS_PER_INIT = 32;
  localparam int unsigned NUM_INIT       = 16;

  typedef logic [7:0] mem_t [DEPTH];

  // Selects one of the 16 INIT slices by index.
  function automatic logic [255:0] init_slice(input int unsigned idx);
    logic [255:0] s;
    s = 256'h0;
    case (idx)
      0:  s = INIT_0;
      1:  s = INIT_1;
      2:  s = INIT_2;
      3:  s = INIT_3;
      4:  s = INIT_4;
      5:  s = INIT_5;
      6:  s = INIT_6;
      7:  s = INIT_7;
      8:  s = INIT_8;
      9:  s = INIT_9;
      10: s = INIT_A;
      11: s = INIT_B;
      12: s = INIT_C;
      13: s = INIT_D;
      14: s = INIT_E;
      15: s = INIT_F;
      default: s = 256'h0;
    endcase
    return s;
  endfunction

  // Unpacks the 16 INIT slices into a word image. Word n*32+k comes from
  // bits [8k+7:8k] of INIT_n.
  function automatic mem_t init_image();
    mem_t         img;
    logic [255:0] slice;
    for (int unsigned p = 0; p < NUM_INIT; p++) begin
      slice = init_slice(p);
      for (int unsigned k = 0; k < WORDS_PER_INIT; k++) begin
        img[p*WORDS_PER_INIT + k] = slice[8*k +: 8];
      end
    end
    return img;
  endfunction

  // The storage array is preloaded at time zero and is never reset. The
  // declaration initializer is the power-up image that block-RAM inference
  // picks up.
  mem_t mem_q = init_image();

  logic       wr_en;
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  // Holding rstn low must also block writes, so rstn qualifies the strobe.
  always_comb begin
    wr_en   = rstn && wclke && we;
    rdata_d = rdata_q;
    if (rclke && re) begin
      // mem_q still holds the pre-edge contents, so a read and a write to
      // the same address on one edge return the old data (read-before-write).
      rdata_d = mem_q[raddr];
    end
  end

  // NOTE: the array has no reset branch. Resetting a memory would turn it
  // into 4096 flops and would destroy the preloaded image.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its pre-edge inputs regardless of the order the blocks run in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_ram512x8_sdp.sv
// ----------------------------------------------------------------------------
// tb_ram512x8_sdp
//   Directed testbench for ram512x8_sdp. A reference model (a plain byte array
//   plus an expected read value) is compared with rdata on every falling
//   edge. Literal expectations at key points pin down the model itself.
// ----------------------------------------------------------------------------
module tb_ram512x8_sdp;

  logic       clk;
  logic       rstn;
  logic [7:0] rdata;
  logic [8:0] raddr;
  logic       rclke;
  logic       re;
  logic [8:0] waddr;
  logic       wclke;
  logic [7:0] wdata;
  logic       we;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] P_INIT_0 = {248'h0, 8'hA5};
  localparam logic [255:0] P_INIT_F = {8'h3C, 248'h0};

  ram512x8_sdp #(
    .INIT_0(P_INIT_0),
    .INIT_F(P_INIT_F)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rdata (rdata),
    .raddr (raddr),
    .rclke (rclke),
    .re    (re),
    .waddr (waddr),
    .wclke (wclke),
    .wdata (wdata),
    .we    (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the memory image, plus the value rdata must show.
  logic [7:0] m_mem [512] = '{0: 8'hA5, 511: 8'h3C, default: 8'h00};
  logic [7:0] m_rdata = 8'h00;
  logic       model_on = 1'b0;

  // The write updates the model after the read has taken the old word.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_rdata <= 8'h00;
    end else begin
      if (rclke && re) m_rdata <= m_mem[raddr];
      if (wclke && we) m_mem[waddr] <= wdata;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: rdata=%02h expected=%02h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Compares the DUT with the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_on) check("model", rdata, m_rdata);
  end

  // Drives one cycle of stimulus from a falling edge. Returns on the next
  // falling edge, where rdata already reflects the rising edge between them.
  task automatic cyc(input logic r_en, input logic [8:0] ra, input logic r_clke,
                     input logic w_en, input logic [8:0] wa, input logic [7:0] wd,
                     input logic w_clke);
    re    = r_en;
    raddr = ra;
    rclke = r_clke;
    we    = w_en;
    waddr = wa;
    wdata = wd;
    wclke = w_clke;
    @(negedge clk);
  endtask

  task automatic rd(input logic [8:0] ra);
    cyc(1'b1, ra, 1'b1, 1'b0, 9'd0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [8:0] wa, input logic [7:0] wd);
    cyc(1'b0, 9'd0, 1'b0, 1'b1, wa, wd, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 8'h00, 1'b0);
  endtask

  initial begin
    rstn  = 1'b1;
    raddr = '0; rclke = 1'b0; re = 1'b0;
    waddr = '0; wclke = 1'b0; wdata = '0; we = 1'b0;
    #3 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", rdata, 8'h00);
    rstn     = 1'b1;
    model_on = 1'b1;
    idle();

    // 1. Init readback
    rd(9'd0);    check("init_addr0",   rdata, 8'hA5);
    rd(9'd511);  check("init_addr511", rdata, 8'h3C);
    rd(9'd1);    check("init_addr1",   rdata, 8'h00);

    // 2. Write then read latency
    wr(9'h123, 8'h5A);
    rd(9'h123);  check("wr_rd_123",   rdata, 8'h5A);
    rd(9'h124);  check("rd_124",      rdata, 8'h00);

    // 3. Enable gating
    cyc(1'b0, 9'd0, 1'b0, 1'b1, 9'd7, 8'hFF, 1'b0);   // we=1, wclke=0
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 9'd7, 8'hFF, 1'b1);   // we=0, wclke=1
    rd(9'd7);    check("gated_write_7", rdata, 8'h00);
    rd(9'h123);  check("prime_5a",      rdata, 8'h5A);
    cyc(1'b0, 9'd7, 1'b1, 1'b0, 9'd0, 8'h00, 1'b0);   // rclke=1, re=0
    check("hold_re0", rdata, 8'h5A);
    cyc(1'b1, 9'd7, 1'b0, 1'b0, 9'd0, 8'h00, 1'b0);   // rclke=0, re=1
    check("hold_rclke0", rdata, 8'h5A);

    // 4. Read-during-write
    wr(9'd10, 8'h11);
    cyc(1'b1, 9'd10, 1'b1, 1'b1, 9'd10, 8'h22, 1'b1);
    check("rdw_old", rdata, 8'h11);
    rd(9'd10);   check("rdw_new", rdata, 8'h22);
    cyc(1'b1, 9'd30, 1'b1, 1'b1, 9'd20, 8'h77, 1'b1);
    check("indep_rd30", rdata, 8'h00);
    rd(9'd20);   check("indep_wr20", rdata, 8'h77);

    // 5. Async reset mid-operation
    rd(9'h123);  check("pre_reset_5a", rdata, 8'h5A);
    #2 rstn = 1'b0;
    #1 check("async_clear", rdata, 8'h00);
    re = 1'b1; rclke = 1'b1; raddr = 9'h123;
    we = 1'b1; wclke = 1'b1; waddr = 9'd3; wdata = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", rdata, 8'h00);
    rstn = 1'b1;
    idle();
    rd(9'd3);    check("reset_no_write", rdata, 8'h00);
    rd(9'h123);  check("mem_retained",  rdata, 8'h5A);

    // 6. Sweep: write every address, then read back to back
    for (int i = 0; i < 512; i++) begin
      wr(i[8:0], i[7:0] ^ 8'hC3);
    end
    for (int i = 0; i < 512; i++) begin
      rd(i[8:0]);
      check("sweep", rdata, i[7:0] ^ 8'hC3);
    end
    idle();

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
